// File: rtl/osd_cmd_tx.sv
// osd_cmd_tx: frames single-cycle OSD requests into io_osd/io_strobe/io_din word sequences.
// Optional `OSD_FILL_EN adds fill_en/fill_byte so a WRITE sends a constant byte instead of RAM data.
module osd_cmd_tx #(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2,
  parameter int END_GAP   = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_row,
  input  logic [12:0] req_len,
  input  logic [11:0] info_x,
  input  logic [11:0] info_y,
  input  logic [5:0]  info_w,
  input  logic [5:0]  info_h,
  input  logic [1:0]  info_rot,
`ifdef OSD_FILL_EN
  input  logic        fill_en,
  input  logic [7:0]  fill_byte,
`endif
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [12:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din
);
  localparam int SH = STROBE_HI < 1 ? 1 : STROBE_HI;
  localparam int SL = STROBE_LO < 2 ? 2 : STROBE_LO;
  localparam int EG = END_GAP < 2 ? 2 : END_GAP;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HI, S_LO, S_END} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_cnt;
  logic [1:0]  r_op;
  logic [4:0]  r_row;
  logic [12:0] r_plen, r_idx;
  logic [11:0] r_x, r_y;
  logic [5:0]  r_w, r_h;
  logic [1:0]  r_rot;
  logic [15:0] r_din;
  logic        r_done;
  logic [13:0] w_room;
  logic [12:0] w_len, w_plen;
  logic [7:0]  w_cmd, w_fbyte;
  logic [15:0] w_field;
  logic        w_accept, w_last, w_more, w_write, w_info, w_fill, w_fetch, w_byp;
`ifdef OSD_FILL_EN
  logic       r_fill;
  logic [7:0] r_fbyte;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_fill  <= 1'b0;
      r_fbyte <= 8'h00;
    end else if (w_accept) begin
      r_fill  <= fill_en;
      r_fbyte <= fill_byte;
    end
  assign w_fill  = r_fill;
  assign w_fbyte = r_fbyte;
`else
  assign w_fill  = 1'b0;
  assign w_fbyte = 8'h00;
`endif
  // a write never runs past the end of the 8 KB source space
  assign w_room   = 14'd8192 - {1'b0, req_row, 8'h00};
  assign w_len    = ({1'b0, req_len} > w_room) ? w_room[12:0] : req_len;
  assign w_plen   = req_op == 2'd0 ? w_len : req_op == 2'd2 ? 13'd5 : 13'd0;
  assign w_cmd    = req_op == 2'd0 ? {3'b001, req_row} : req_op == 2'd1 ? 8'h41 :
                    req_op == 2'd2 ? 8'h45 : 8'h40;
  assign w_field  = r_idx == 13'd0 ? {4'h0, r_x} : r_idx == 13'd1 ? {4'h0, r_y} :
                    r_idx == 13'd2 ? {10'h0, r_w} : r_idx == 13'd3 ? {10'h0, r_h} : {14'h0, r_rot};
  assign w_accept = r_state == S_IDLE && req;
  assign w_more   = r_idx < r_plen;
  assign w_write  = r_op == 2'd0;
  assign w_info   = r_op == 2'd2;
  assign w_last   = r_state == S_SETUP || (r_state == S_HI && r_cnt == 16'(SH - 1)) ||
                    (r_state == S_LO && r_cnt == 16'(SL - 1)) || (r_state == S_END && r_cnt == 16'(EG - 1));
  assign w_fetch  = r_state == S_LO && r_cnt == 16'd0 && w_more && w_write && !w_fill;
  // RAM data arrives in the second LO cycle; forward it so io_din settles before the strobe rises
  assign w_byp    = r_state == S_LO && r_cnt == 16'd1 && w_more && w_write && !w_fill;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? 16'd0 : r_cnt + 16'd1;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = req ? S_SETUP : S_IDLE;
      S_SETUP: w_next = S_HI;
      S_HI:    w_next = w_last ? S_LO : S_HI;
      S_LO:    w_next = w_last ? (w_more ? S_HI : S_END) : S_LO;
      S_END:   w_next = w_last ? S_IDLE : S_END;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    busy      = r_state != S_IDLE;
    io_osd    = r_state == S_SETUP || r_state == S_HI || r_state == S_LO;
    io_strobe = r_state == S_HI;
    rd_en     = w_fetch;
    io_din    = w_byp ? {8'h00, rd_data} : r_din;
  end
  assign done    = r_done;
  assign rd_addr = {r_row, 8'h00} + r_idx;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_op   <= '0;
      r_row  <= '0;
      r_plen <= '0;
      r_idx  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_w    <= '0;
      r_h    <= '0;
      r_rot  <= '0;
      r_din  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= r_state == S_END && w_last;
      if (w_accept) begin
        r_op   <= req_op;
        r_row  <= req_row;
        r_plen <= w_plen;
        r_idx  <= '0;
        r_x    <= info_x;
        r_y    <= info_y;
        r_w    <= info_w;
        r_h    <= info_h;
        r_rot  <= info_rot;
        r_din  <= {8'h00, w_cmd};
      end else if (r_state == S_LO) begin
        if (r_cnt == 16'd0 && w_more && w_info) r_din <= w_field;
        if (r_cnt == 16'd0 && w_more && w_write && w_fill) r_din <= {8'h00, w_fbyte};
        if (w_byp) r_din <= {8'h00, rd_data};
        if (w_last && w_more) r_idx <= r_idx + 13'd1;
        if (w_last && !w_more) r_din <= '0;
      end
    end
endmodule

// File: tb/tb_osd_cmd_tx.sv
// tb_osd_cmd_tx: table-driven directed bench for osd_cmd_tx with a word-capturing bus monitor.
module tb_osd_cmd_tx;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0;
  logic [1:0]  req_op = '0, info_rot = '0;
  logic [4:0]  req_row = '0;
  logic [12:0] req_len = '0, rd_addr;
  logic [11:0] info_x = '0, info_y = '0;
  logic [5:0]  info_w = '0, info_h = '0;
  logic        busy, done, rd_en, io_osd, io_strobe;
  logic [7:0]  rd_data = '0;
  logic [15:0] io_din;
`ifdef OSD_FILL_EN
  logic        f_en = 1'b0;
  logic [7:0]  f_byte = '0;
`endif
  logic [7:0]  mem [8192];
  logic [15:0] words[$];
  int          n_rd, gap, viol, n_done, lat, n_vec = 0, n_err = 0;
  logic [12:0] last_addr;
  logic        p_strobe = 1'b0, p_osd = 1'b0;
  logic [15:0] p_din = '0;

  typedef struct {
    logic [1:0] op; logic [4:0] row; logic [12:0] len;
    logic [11:0] x, y; logic [5:0] w, h; logic [1:0] rot;
    int nw; logic [15:0] first, last; int lat; int nrd; logic [12:0] laddr;
  } vec_t;
  vec_t vecs[8];
  logic [15:0] exp_wr[4];
  logic [15:0] exp_inf[6];

  osd_cmd_tx dut (
    .clk_sys(clk), .reset(rst), .req(req), .req_op(req_op), .req_row(req_row), .req_len(req_len),
    .info_x(info_x), .info_y(info_y), .info_w(info_w), .info_h(info_h), .info_rot(info_rot),
`ifdef OSD_FILL_EN
    .fill_en(f_en), .fill_byte(f_byte),
`endif
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (io_strobe && !p_strobe) begin
      words.push_back(io_din);
      if (!p_osd) viol <= viol + 1;
    end
    if (io_strobe && io_din !== p_din) viol <= viol + 1;
    if (rd_en) begin
      n_rd <= n_rd + 1;
      last_addr <= rd_addr;
    end
    if (busy && !io_osd) gap <= gap + 1;
    if (done) n_done <= n_done + 1;
    p_strobe <= io_strobe;
    p_osd <= io_osd;
    p_din <= io_din;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    words.delete();
    n_rd = 0; gap = 0; viol = 0; n_done = 0; lat = 0; last_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    req = 1'b1; req_op = v.op; req_row = v.row; req_len = v.len;
    info_x = v.x; info_y = v.y; info_w = v.w; info_h = v.h; info_rot = v.rot;
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    clr();
    drive(v);
    while (lat < 5000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req = 1'b0;
      if (done) break;
    end
    if (lat >= 5000) $display("FAIL timeout: no done within %0d cycles", lat);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = i[7:0];
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC;
    //          op    row    len      x        y       w     h     rot  nw   first     last      lat   nrd  laddr
    vecs[0] = '{2'd1, 5'd0,  13'd0,   12'h0,   12'h0,   6'd0, 6'd0, 2'd0, 1,   16'h0041, 16'h0041, 10,   0,   13'd0};
    vecs[1] = '{2'd3, 5'd0,  13'd0,   12'h0,   12'h0,   6'd0, 6'd0, 2'd0, 1,   16'h0040, 16'h0040, 10,   0,   13'd0};
    vecs[2] = '{2'd2, 5'd0,  13'd0,   12'h123, 12'h045, 6'd10,6'd4, 2'd1, 6,   16'h0045, 16'h0001, 30,   0,   13'd0};
    vecs[3] = '{2'd0, 5'd0,  13'd3,   12'h0,   12'h0,   6'd0, 6'd0, 2'd0, 4,   16'h0020, 16'h00CC, 22,   3,   13'd2};
    vecs[4] = '{2'd0, 5'd31, 13'd300, 12'h0,   12'h0,   6'd0, 6'd0, 2'd0, 257, 16'h003F, 16'h00FF, 1034, 256, 13'd8191};
    vecs[5] = '{2'd0, 5'd8,  13'd0,   12'h0,   12'h0,   6'd0, 6'd0, 2'd0, 1,   16'h0028, 16'h0028, 10,   0,   13'd0};
    vecs[6] = '{2'd0, 5'd5,  13'd2,   12'h0,   12'h0,   6'd0, 6'd0, 2'd0, 3,   16'h0025, 16'h0001, 18,   2,   13'h501};
    vecs[7] = '{2'd0, 5'd30, 13'd600, 12'h0,   12'h0,   6'd0, 6'd0, 2'd0, 513, 16'h003E, 16'h00FF, 2058, 512, 13'd8191};
    exp_wr  = '{16'h0020, 16'h00AA, 16'h00BB, 16'h00CC};
    exp_inf = '{16'h0045, 16'h0123, 16'h0045, 16'h000A, 16'h0004, 16'h0001};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_osd", io_osd, 0);
    chk("rst_strobe", io_strobe, 0);
    chk("rst_din", io_din, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i]);
      chk($sformatf("v%0d_nwords", i), words.size(), vecs[i].nw);
      chk($sformatf("v%0d_first", i), words[0], vecs[i].first);
      chk($sformatf("v%0d_last", i), words[words.size() - 1], vecs[i].last);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_reads", i), n_rd, vecs[i].nrd);
      chk($sformatf("v%0d_last_addr", i), last_addr, vecs[i].laddr);
      chk($sformatf("v%0d_end_gap", i), gap, 4);
      chk($sformatf("v%0d_bus_rules", i), viol, 0);
      chk($sformatf("v%0d_done_pulses", i), n_done, 1);
    end

    run(vecs[3]);
    for (int i = 0; i < 4; i++) chk($sformatf("wr_word%0d", i), words[i], exp_wr[i]);
    run(vecs[2]);
    for (int i = 0; i < 6; i++) chk($sformatf("info_word%0d", i), words[i], exp_inf[i]);

    // second request while busy must be dropped
    @(negedge clk);
    clr();
    drive(vecs[1]);
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    chk("drop_nwords", words.size(), 1);
    chk("drop_word", words[0], 16'h0040);
    chk("drop_done", n_done, 1);

    // reset in the middle of a long write
    @(negedge clk);
    clr();
    drive('{2'd0, 5'd2, 13'd100, 12'h0, 12'h0, 6'd0, 6'd0, 2'd0, 0, 16'h0, 16'h0, 0, 0, 13'd0});
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < 2000 && words.size() < 51; k++) @(negedge clk);
    chk("mid_reached", words.size(), 51);
    #2 rst = 1'b1;
    #1;
    chk("mid_osd", io_osd, 0);
    chk("mid_strobe", io_strobe, 0);
    chk("mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_done", n_done, 0);
    run(vecs[1]);
    chk("post_word", words[0], 16'h0040);
    chk("post_latency", lat, 10);
    chk("post_done", n_done, 1);

`ifdef OSD_FILL_EN
    f_en = 1'b1;
    f_byte = 8'h00;
    run('{2'd0, 5'd8, 13'd256, 12'h0, 12'h0, 6'd0, 6'd0, 2'd0, 0, 16'h0, 16'h0, 0, 0, 13'd0});
    f_en = 1'b0;
    begin
      int nz = 0;
      for (int i = 1; i < words.size(); i++) if (words[i] != 16'h0000) nz++;
      chk("fill_nonzero", nz, 0);
    end
    chk("fill_nwords", words.size(), 257);
    chk("fill_cmd", words[0], 16'h0028);
    chk("fill_reads", n_rd, 0);
    chk("fill_latency", lat, 1034);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
